// File: rtl/wa_buffer_ctrl.sv
// Sequencer for the word-addressable ifmap line buffer: fills it row by row from the loader,
// then streams sliding-window rows to the PE array across the buffer's 1-cycle read latency.
module wa_buffer_ctrl #(
    parameter int unsigned Depth      = 5,
    parameter int unsigned AddrWidth  = $clog2(Depth),
    parameter int unsigned KernelSize = 3,
    parameter int unsigned Stride     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AddrWidth:0]   cfg_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 buf_write_en,
    output logic [AddrWidth-1:0] buf_write_addr,
    output logic [AddrWidth-1:0] buf_read_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last_k,
    output logic                 out_last
);

    localparam int unsigned KWidth   = (KernelSize > 1) ? $clog2(KernelSize) : 1;
    localparam int unsigned SumWidth = AddrWidth + 3;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StStream = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam logic [SumWidth-1:0]  KExt      = SumWidth'(KernelSize);
    localparam logic [SumWidth-1:0]  StrideExt = SumWidth'(Stride);
    localparam logic [SumWidth-1:0]  DepthExt  = SumWidth'(Depth);
    localparam logic [AddrWidth:0]   CfgOne    = (AddrWidth + 1)'(1);
    localparam logic [AddrWidth-1:0] AddrOne   = AddrWidth'(1);
    localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(Stride);
    localparam logic [KWidth-1:0]    KOne      = KWidth'(1);
    localparam logic [KWidth-1:0]    KMax      = KWidth'(KernelSize - 1);

    logic [1:0]           state_q, state_d;
    logic [AddrWidth:0]   cfg_q, cfg_d;
    logic [AddrWidth-1:0] load_cnt_q, load_cnt_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [KWidth-1:0]    k_q, k_d;
    logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
    logic [AddrWidth-1:0] pend_addr_q, pend_addr_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_k_q, out_last_k_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                cfg_ok;
    logic                issue;
    logic                hs;
    logic                k_last;
    logic                win_last;
    logic                addr_last;
    logic [SumWidth-1:0] cfg_in_ext;
    logic [SumWidth-1:0] next_win_end;

    always_comb begin
        cfg_in_ext   = SumWidth'(cfg_rows);
        cfg_ok       = (cfg_in_ext >= KExt) && (cfg_in_ext <= DepthExt);
        load_ready   = (state_q == StLoad);
        buf_write_en = load_valid & load_ready;
        buf_write_addr = load_cnt_q;
        hs           = out_valid_q & out_ready;
        issue        = (state_q == StStream) && (!out_valid_q || out_ready);
        k_last       = (k_q == KMax);
        // The current window is the last one if the next window would run past cfg_rows.
        next_win_end = SumWidth'(base_q) + StrideExt + KExt;
        win_last     = (next_win_end > SumWidth'(cfg_q));
        addr_last    = k_last && win_last;
        // While stalled, re-read the presented row so dataOut stays stable.
        buf_read_addr = (out_valid_q && !out_ready) ? pend_addr_q : cur_addr_q;
        busy         = (state_q != StIdle);
        done         = done_q;
        err          = err_q;
        out_valid    = out_valid_q;
        out_last_k   = out_last_k_q;
        out_last     = out_last_q;
    end

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        load_cnt_d   = load_cnt_q;
        base_d       = base_q;
        k_d          = k_q;
        cur_addr_d   = cur_addr_q;
        pend_addr_d  = pend_addr_q;
        out_valid_d  = out_valid_q;
        out_last_k_d = out_last_k_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        cfg_d      = cfg_rows;
                        load_cnt_d = '0;
                        state_d    = StLoad;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (buf_write_en) begin
                    if ({1'b0, load_cnt_q} == cfg_q - CfgOne) begin
                        load_cnt_d = '0;
                        base_d     = '0;
                        k_d        = '0;
                        cur_addr_d = '0;
                        state_d    = StStream;
                    end else begin
                        load_cnt_d = load_cnt_q + AddrOne;
                    end
                end
            end
            StStream: begin
                if (issue) begin
                    pend_addr_d  = cur_addr_q;
                    out_valid_d  = 1'b1;
                    out_last_k_d = k_last;
                    out_last_d   = addr_last;
                    if (addr_last) begin
                        base_d     = '0;
                        k_d        = '0;
                        cur_addr_d = '0;
                        state_d    = StDrain;
                    end else if (k_last) begin
                        base_d     = base_q + AddrStep;
                        k_d        = '0;
                        cur_addr_d = base_q + AddrStep;
                    end else begin
                        k_d        = k_q + KOne;
                        cur_addr_d = cur_addr_q + AddrOne;
                    end
                end
            end
            StDrain: begin
                if (hs && out_last_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (hs && !issue) begin
            out_valid_d  = 1'b0;
            out_last_k_d = 1'b0;
            out_last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cfg_q        <= '0;
            load_cnt_q   <= '0;
            base_q       <= '0;
            k_q          <= '0;
            cur_addr_q   <= '0;
            pend_addr_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_k_q <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            load_cnt_q   <= load_cnt_d;
            base_q       <= base_d;
            k_q          <= k_d;
            cur_addr_q   <= cur_addr_d;
            pend_addr_q  <= pend_addr_d;
            out_valid_q  <= out_valid_d;
            out_last_k_q <= out_last_k_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule
